change_dispenser: RTL

CHANGE_DISPENSER -- requirements
Module: change_dispenser

---
 rtl/change_dispenser_if.sv | 44 ++++
 rtl/change_dispenser.sv | 225 ++++++++++++++++++++++
 2 files changed

// File: rtl/change_dispenser_if.sv
// -----------------------------------------------------------------------------
// change_dispenser_if
//   Groups the request, refill, coin-mechanism and status signals of the
//   change dispenser into one bundle. clk and reset are not part of the bundle.
//
//   master modport (the environment / vending controller side):
//     outputs: start, paid[7:0], price[7:0], refill_5/10/20, eject_ack
//     inputs : eject_5/10/20, busy, done, short, fault, remaining[7:0],
//              stock_5/10/20[3:0]
//   slave modport (the dispenser itself): the same signals, opposite direction.
// -----------------------------------------------------------------------------
interface change_dispenser_if;
    logic       start;
    logic [7:0] paid;
    logic [7:0] price;
    logic       refill_5;
    logic       refill_10;
    logic       refill_20;
    logic       eject_ack;

    logic       eject_5;
    logic       eject_10;
    logic       eject_20;
    logic       busy;
    logic       done;
    logic       short;
    logic       fault;
    logic [7:0] remaining;
    logic [3:0] stock_5;
    logic [3:0] stock_10;
    logic [3:0] stock_20;

    modport master (
        output start, paid, price, refill_5, refill_10, refill_20, eject_ack,
        input  eject_5, eject_10, eject_20, busy, done, short, fault,
               remaining, stock_5, stock_10, stock_20
    );

    modport slave (
        input  start, paid, price, refill_5, refill_10, refill_20, eject_ack,
        output eject_5, eject_10, eject_20, busy, done, short, fault,
               remaining, stock_5, stock_10, stock_20
    );
endinterface

// File: rtl/change_dispenser.sv
// -----------------------------------------------------------------------------
// change_dispenser
//   Pays out change (paid - price) with coins of 20, 10 and 5 units, choosing
//   the largest coin that fits and is in stock, one coin at a time. Every coin
//   is requested on a one-hot eject line and held until the coin mechanism
//   acknowledges it; a missing acknowledge within ACK_TIMEOUT cycles locks the
//   block in a sticky fault until reset. Coin stocks (0..15) are refilled by
//   single-cycle pulses at any time.
//
//   Parameters
//     INIT_STOCK   coins of each denomination loaded at reset (0..15)
//     ACK_TIMEOUT  cycles an eject request may wait for eject_ack (1..255)
//
//   Ports
//     clk          rising-edge clock
//     reset        asynchronous, active-high reset
//     bus          change_dispenser_if.slave:
//                    start/paid/price    dispense request
//                    refill_5/10/20      add one coin to a stock
//                    eject_ack           coin released by the mechanism
//                    eject_5/10/20       one-hot coin release request
//                    busy/done/short     progress and result
//                    fault               sticky acknowledge-timeout flag
//                    remaining           change still owed
//                    stock_5/10/20       current coin counts
// -----------------------------------------------------------------------------
module change_dispenser #(
    parameter int INIT_STOCK  = 4,
    parameter int ACK_TIMEOUT = 255
) (
    input  logic              clk,
    input  logic              reset,
    change_dispenser_if.slave bus
);

    typedef enum logic [2:0] {
        IDLE,
        SELECT,
        EJECT,
        DONE,
        FAULT
    } state_t;

    localparam logic [3:0] INIT_COUNT   = 4'(INIT_STOCK);
    localparam logic [3:0] STOCK_MAX    = 4'd15;
    // The timer starts at 0 on entry to EJECT, so the request has been
    // outstanding ACK_TIMEOUT cycles when the timer holds ACK_TIMEOUT-1.
    localparam logic [7:0] TIMEOUT_LAST = 8'(ACK_TIMEOUT - 1);

    // Index 0 = 5-unit coin, 1 = 10-unit coin, 2 = 20-unit coin throughout.
    localparam logic [7:0] COIN_VALUE [3] = '{8'd5, 8'd10, 8'd20};

    state_t     state_reg;
    logic [7:0] remaining_reg;
    logic [2:0] eject_reg;
    logic       busy_reg;
    logic       done_reg;
    logic       short_reg;
    logic       fault_reg;
    logic [7:0] timer_reg;

    logic [3:0] stock_cnt [3];
    logic [2:0] refill;
    logic [2:0] avail;
    logic [2:0] take;
    logic [2:0] pick;
    logic [7:0] taken_value;

    assign refill = {bus.refill_20, bus.refill_10, bus.refill_5};

    // -------------------------------------------------------------------------
    // Per-denomination logic: eligibility, ack-driven decrement, stock counter.
    // -------------------------------------------------------------------------
    genvar gi;
    generate
        for (gi = 0; gi < 3; gi++) begin : g_coin
            logic [3:0] count_reg;

            // Eligibility uses the registered stock, so a refill landing in a
            // SELECT cycle only influences the following decision.
            assign avail[gi] = (count_reg != 4'd0) &&
                               (remaining_reg >= COIN_VALUE[gi]);

            // A coin leaves the stock only on an acknowledged request for it.
            assign take[gi]  = (state_reg == EJECT) && bus.eject_ack &&
                               eject_reg[gi];

            always_ff @(posedge clk or posedge reset) begin
                if (reset) begin
                    count_reg <= INIT_COUNT;
                end else begin
                    case ({refill[gi], take[gi]})
                        2'b10: begin
                            // Refill at full stock is dropped.
                            if (count_reg != STOCK_MAX) begin
                                count_reg <= count_reg + 4'd1;
                            end
                        end
                        2'b01: begin
                            count_reg <= count_reg - 4'd1;
                        end
                        // Refill and payout of the same coin cancel out.
                        default: begin
                            count_reg <= count_reg;
                        end
                    endcase
                end
            end

            assign stock_cnt[gi] = count_reg;
        end
    endgenerate

    // Greedy choice: largest eligible coin wins.
    always_comb begin
        pick = 3'b000;
        if (avail[2]) begin
            pick = 3'b100;
        end else if (avail[1]) begin
            pick = 3'b010;
        end else if (avail[0]) begin
            pick = 3'b001;
        end
    end

    // Value of the coin currently being requested (eject_reg is one-hot).
    always_comb begin
        taken_value = 8'd0;
        for (int i = 0; i < 3; i++) begin
            if (eject_reg[i]) begin
                taken_value = taken_value | COIN_VALUE[i];
            end
        end
    end

    // -------------------------------------------------------------------------
    // Control FSM with registered outputs.
    // -------------------------------------------------------------------------
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_reg     <= IDLE;
            remaining_reg <= 8'd0;
            eject_reg     <= 3'b000;
            busy_reg      <= 1'b0;
            done_reg      <= 1'b0;
            short_reg     <= 1'b0;
            fault_reg     <= 1'b0;
            timer_reg     <= 8'd0;
        end else begin
            done_reg <= 1'b0;
            case (state_reg)
                IDLE: begin
                    if (bus.start) begin
                        remaining_reg <= (bus.paid >= bus.price) ?
                                         (bus.paid - bus.price) : 8'd0;
                        short_reg     <= 1'b0;
                        busy_reg      <= 1'b1;
                        state_reg     <= SELECT;
                    end
                end

                SELECT: begin
                    if (remaining_reg == 8'd0) begin
                        done_reg  <= 1'b1;
                        state_reg <= DONE;
                    end else if (pick != 3'b000) begin
                        eject_reg <= pick;
                        timer_reg <= 8'd0;
                        state_reg <= EJECT;
                    end else begin
                        // Owed amount cannot be formed from what is in stock;
                        // remaining keeps the unpaid balance.
                        short_reg <= 1'b1;
                        done_reg  <= 1'b1;
                        state_reg <= DONE;
                    end
                end

                EJECT: begin
                    if (bus.eject_ack) begin
                        remaining_reg <= remaining_reg - taken_value;
                        eject_reg     <= 3'b000;
                        state_reg     <= SELECT;
                    end else if (timer_reg == TIMEOUT_LAST) begin
                        eject_reg <= 3'b000;
                        fault_reg <= 1'b1;
                        busy_reg  <= 1'b0;
                        state_reg <= FAULT;
                    end else begin
                        timer_reg <= timer_reg + 8'd1;
                    end
                end

                DONE: begin
                    busy_reg  <= 1'b0;
                    state_reg <= IDLE;
                end

                FAULT: begin
                    // Locked until reset.
                    state_reg <= FAULT;
                end

                default: begin
                    eject_reg <= 3'b000;
                    busy_reg  <= 1'b0;
                    state_reg <= IDLE;
                end
            endcase
        end
    end

    assign bus.eject_5   = eject_reg[0];
    assign bus.eject_10  = eject_reg[1];
    assign bus.eject_20  = eject_reg[2];
    assign bus.busy      = busy_reg;
    assign bus.done      = done_reg;
    assign bus.short     = short_reg;
    assign bus.fault     = fault_reg;
    assign bus.remaining = remaining_reg;
    assign bus.stock_5   = stock_cnt[0];
    assign bus.stock_10  = stock_cnt[1];
    assign bus.stock_20  = stock_cnt[2];

endmodule
